// File: rtl/hazard3_fetch_cir.sv
// Fetch frontend: issues word fetches on a pipelined req/gnt/rvld bus, buffers
// returned words in a small FIFO and presents up to two halfwords to decode.
module hazard3_fetch_cir #(
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter int          FIFO_DEPTH   = 2,
    parameter int          MAX_OUTSTND  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvld,
    input  logic [31:0] mem_rdata,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    output logic        f_jump_rdy,
    output logic        f_jump_now,
    output logic [31:0] f_jump_target,
    output logic [31:0] fd_cir,
    output logic [1:0]  fd_cir_vld,
    input  logic [1:0]  df_cir_use,
    input  logic        df_cir_lock
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    // Back-to-back jumps can stack discards above MAX_OUTSTND, so leave headroom.
    localparam int OW = 4;

    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;
    logic          skip_half_q, skip_half_d;
    logic          flush_pending_q, flush_pending_d;
    logic [31:0]   jump_target_q, jump_target_d;
    logic [31:0]   cir_q, cir_d;
    logic [1:0]    cir_vld_q, cir_vld_d;

    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [1:0]    fifo_hv_q   [FIFO_DEPTH];
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] level_q, level_d;

    logic          credit_ok;
    logic          seq_gnt;
    logic          rvld_keep;
    logic          fifo_empty;
    logic [31:0]   head_data;
    logic [1:0]    head_hv;
    logic [1:0]    rdata_hv;

    logic          fifo_flush;
    logic          push;
    logic [1:0]    push_hv;
    logic          pop;
    logic          head_part;

    logic [1:0]    lvl;
    logic [31:0]   keep;
    logic [31:0]   src_data;
    logic [1:0]    src_hv;
    logic          src_fifo;
    logic [15:0]   h0;
    logic [1:0]    src_n;
    logic [1:0]    take;

    assign credit_ok = !df_cir_lock
        && (32'(level_q) + 32'(outstanding_q) < 32'(FIFO_DEPTH))
        && (32'(outstanding_q) < 32'(MAX_OUTSTND));

    assign mem_req       = rst_n & (jump_req | credit_ok);
    assign mem_addr      = jump_req ? {jump_target[31:2], 2'b00} : fetch_addr_q;
    assign f_jump_rdy    = mem_gnt;
    assign f_jump_now    = rst_n & jump_req & mem_gnt;
    assign f_jump_target = jump_target_q;
    assign fd_cir        = cir_q;
    assign fd_cir_vld    = cir_vld_q;

    assign seq_gnt    = mem_req & mem_gnt & !jump_req;
    // A response arriving alongside a taken jump always belongs to the old stream.
    assign rvld_keep  = mem_rvld & (discard_q == '0) & !f_jump_now;
    assign fifo_empty = (level_q == '0);
    assign head_data  = fifo_data_q[rptr_q];
    assign head_hv    = fifo_hv_q[rptr_q];
    assign rdata_hv   = skip_half_q ? 2'b10 : 2'b11;

    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        skip_half_d   = skip_half_q;
        jump_target_d = jump_target_q;
        if (f_jump_now) begin
            discard_d     = outstanding_q - OW'(mem_rvld);
            outstanding_d = outstanding_q - OW'(mem_rvld) + OW'(1);
            fetch_addr_d  = {jump_target[31:2], 2'b00} + 32'd4;
            skip_half_d   = jump_target[1];
            jump_target_d = jump_target;
        end else begin
            outstanding_d = outstanding_q + OW'(seq_gnt) - OW'(mem_rvld);
            if (mem_rvld && discard_q != '0)
                discard_d = discard_q - OW'(1);
            if (seq_gnt)
                fetch_addr_d = fetch_addr_q + 32'd4;
            if (rvld_keep)
                skip_half_d = 1'b0;
        end
    end

    always_comb begin
        cir_d           = cir_q;
        cir_vld_d       = cir_vld_q;
        flush_pending_d = flush_pending_q;
        fifo_flush      = 1'b0;
        push            = 1'b0;
        push_hv         = rdata_hv;
        pop             = 1'b0;
        head_part       = 1'b0;
        lvl             = 2'd0;
        keep            = 32'h0;
        src_data        = 32'h0;
        src_hv          = 2'b00;
        src_fifo        = 1'b0;
        h0              = 16'h0;
        src_n           = 2'd0;
        take            = 2'd0;
        if (f_jump_now) begin
            fifo_flush = 1'b1;
            if (df_cir_lock) begin
                flush_pending_d = 1'b1;
            end else begin
                cir_d           = 32'h0;
                cir_vld_d       = 2'd0;
                flush_pending_d = 1'b0;
            end
        end else if (df_cir_lock) begin
            push = rvld_keep;
        end else begin
            if (flush_pending_q) begin
                flush_pending_d = 1'b0;
            end else begin
                lvl = cir_vld_q - df_cir_use;
                case (df_cir_use)
                    2'd0:    keep = cir_q;
                    2'd1:    keep = {16'h0, cir_q[31:16]};
                    default: keep = 32'h0;
                endcase
            end
            // Buffered words are older than anything on the bus, so they fill first.
            if (!fifo_empty) begin
                src_fifo = 1'b1;
                src_data = head_data;
                src_hv   = head_hv;
            end else if (rvld_keep) begin
                src_data = mem_rdata;
                src_hv   = rdata_hv;
            end
            h0 = src_hv[0] ? src_data[15:0] : src_data[31:16];
            case (src_hv)
                2'b11:   src_n = 2'd2;
                2'b10:   src_n = 2'd1;
                default: src_n = 2'd0;
            endcase
            cir_d     = keep;
            cir_vld_d = lvl;
            if (lvl == 2'd0 && src_n == 2'd2) begin
                cir_d     = src_data;
                cir_vld_d = 2'd2;
                take      = 2'd2;
            end else if (lvl == 2'd0 && src_n == 2'd1) begin
                cir_d     = {16'h0, h0};
                cir_vld_d = 2'd1;
                take      = 2'd1;
            end else if (lvl == 2'd1 && src_n != 2'd0) begin
                cir_d     = {h0, keep[15:0]};
                cir_vld_d = 2'd2;
                take      = 2'd1;
            end
            if (src_fifo) begin
                push      = rvld_keep;
                pop       = (take != 2'd0) && (take == src_n);
                head_part = (take != 2'd0) && (take != src_n);
            end else if (rvld_keep) begin
                push    = (take != src_n);
                push_hv = (take == 2'd0) ? rdata_hv : 2'b10;
            end
        end
    end

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        level_d = level_q;
        if (fifo_flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            level_d = '0;
        end else begin
            if (push)
                wptr_d = wptr_q + PW'(1);
            if (pop)
                rptr_d = rptr_q + PW'(1);
            level_d = level_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_addr_q    <= {RESET_VECTOR[31:2], 2'b00};
            outstanding_q   <= '0;
            discard_q       <= '0;
            skip_half_q     <= RESET_VECTOR[1];
            flush_pending_q <= 1'b0;
            jump_target_q   <= RESET_VECTOR;
            cir_q           <= 32'h0;
            cir_vld_q       <= 2'd0;
            rptr_q          <= '0;
            wptr_q          <= '0;
            level_q         <= '0;
        end else begin
            fetch_addr_q    <= fetch_addr_d;
            outstanding_q   <= outstanding_d;
            discard_q       <= discard_d;
            skip_half_q     <= skip_half_d;
            flush_pending_q <= flush_pending_d;
            jump_target_q   <= jump_target_d;
            cir_q           <= cir_d;
            cir_vld_q       <= cir_vld_d;
            rptr_q          <= rptr_d;
            wptr_q          <= wptr_d;
            level_q         <= level_d;
        end
    end

    // A partially consumed head keeps only its upper halfword.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wptr_q] <= mem_rdata;
            fifo_hv_q[wptr_q]   <= push_hv;
        end
        if (head_part)
            fifo_hv_q[rptr_q] <= 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && level_q == LW'(FIFO_DEPTH)));
            assert (!(df_cir_lock && df_cir_use != 2'd0));
            assert (df_cir_use <= cir_vld_q);
        end
    end

endmodule
